// File: rtl/ram4k_dma.sv
// ---------------------------------------------------------------------------
// ram4k_dma
//   Block fill/copy engine sitting directly in front of a ram4k. While idle the
//   CPU port passes straight through to the RAM; while busy the engine owns the
//   RAM address/data/load pins and either fills a range with a constant or
//   copies a range (overlap-safe by choosing the walk direction).
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   start, mode                   command strobe (IDLE only), 0=fill 1=copy
//   src_addr, dst_addr            copy source base, destination base
//   length                        word count 0..4096 (larger values clip)
//   fill_value                    constant written by a fill
//   busy, done                    engine active / one-cycle completion pulse
//   cpu_address, cpu_in, cpu_load CPU port (load blocked while busy)
//   cpu_out                       RAM read data seen by the CPU
//   mem_address, mem_in, mem_load to ram4k
//   mem_out                       from ram4k (combinational read)
// ---------------------------------------------------------------------------
module ram4k_dma #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_in,
  input  logic              cpu_load,
  output logic [DATA_W-1:0] cpu_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FILL = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_data;

  // Command fields, captured on an accepted start.
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_len;
  logic [DATA_W-1:0] r_fill;
  logic              r_desc;

  logic [ADDR_W:0]   w_len_clip;
  logic [ADDR_W:0]   w_idx_full;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_src_a;
  logic [ADDR_W-1:0] w_dst_a;
  logic              w_last;
  logic              w_accept;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_len_clip = (length > MAX_LEN) ? MAX_LEN : length;
  assign w_last     = (r_cnt == r_len - CNT_ONE);

  // Descending walks index from the top so a forward-overlapping copy reads
  // each source word before it is overwritten.
  assign w_idx_full = r_desc ? (r_len - CNT_ONE - r_cnt) : r_cnt;
  assign w_idx      = w_idx_full[ADDR_W-1:0];

  // Sums are ADDR_W wide, so they wrap modulo the RAM size by construction.
  assign w_src_a = r_src + w_idx;
  assign w_dst_a = r_dst + w_idx;

  // NOTE: command fields have no reset; they are only read after an accepted
  // start has loaded them, so resetting them would add logic for no benefit.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_src  <= src_addr;
      r_dst  <= dst_addr;
      r_len  <= w_len_clip;
      r_fill <= fill_value;
      r_desc <= mode && (dst_addr > src_addr);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (w_len_clip == '0) r_state <= DONE;
            else if (mode)        r_state <= RD;
            else                  r_state <= FILL;
          end
        end
        FILL: begin
          if (w_last) r_state <= DONE;
          else        r_cnt   <= r_cnt + CNT_ONE;
        end
        RD: begin
          r_data  <= mem_out;
          r_state <= WR;
        end
        WR: begin
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            r_state <= RD;
          end
        end
        default: r_state <= IDLE;  // DONE and any illegal encoding
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign cpu_out = mem_out;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    mem_address = cpu_address;
    mem_in      = cpu_in;
    mem_load    = 1'b0;
    case (r_state)
      IDLE: mem_load = cpu_load;
      FILL: begin
        mem_address = w_dst_a;
        mem_in      = r_fill;
        mem_load    = 1'b1;
      end
      RD: begin
        mem_address = w_src_a;
        mem_in      = r_data;
      end
      WR: begin
        mem_address = w_dst_a;
        mem_in      = r_data;
        mem_load    = 1'b1;
      end
      default: begin
        mem_address = w_dst_a;
        mem_in      = r_data;
      end
    endcase
    // Reset blocks writes immediately, before the state register clears.
    if (!reset_n) mem_load = 1'b0;
  end

endmodule

// File: tb/tb_ram4k_dma.sv
// ---------------------------------------------------------------------------
// tb_ram4k_dma
//   Bench for ram4k_dma with a behavioural ram4k attached. A reference memory
//   image is updated from the command semantics (fill / directional copy with
//   wrapping addresses) and compared against the RAM after each command, along
//   with busy duration, done pulse count/timing and the write address order.
// ---------------------------------------------------------------------------
module tb_ram4k_dma;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] fill_value = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] cpu_address = '0;
  logic [DW-1:0] cpu_in = '0;
  logic          cpu_load = 1'b0;
  logic [DW-1:0] cpu_out;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in;
  logic          mem_load;
  logic [DW-1:0] mem_out;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_at = -1;
  int unsigned load_q[$];
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  ram4k_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .cpu_address(cpu_address),
    .cpu_in     (cpu_in),
    .cpu_load   (cpu_load),
    .cpu_out    (cpu_out),
    .mem_address(mem_address),
    .mem_in     (mem_in),
    .mem_load   (mem_load),
    .mem_out    (mem_out)
  );

  // Behavioural ram4k: combinational read, write on rising edge.
  assign mem_out = ram[mem_address];
  always @(posedge clk) if (mem_load === 1'b1) ram[mem_address] <= mem_in;

  // Mid-cycle monitor: busy length, done pulses, engine write addresses.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_cnt++;
      if (mem_load === 1'b1) load_q.push_back(int'(mem_address));
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at = busy_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic check_loads(input string tag);
    bit ok;
    ok = (load_q.size() == exp_q.size());
    if (ok) for (int i = 0; i < exp_q.size(); i++) if (load_q[i] != exp_q[i]) ok = 1'b0;
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic cpu_write(input int unsigned a, input int unsigned d);
    cpu_address = AW'(a);
    cpu_in      = DW'(d);
    cpu_load    = 1'b1;
    #1;
    check("pass_addr", 32'(mem_address), a % DEPTH);
    check("pass_load", 32'(mem_load), 1);
    tick;
    cpu_load = 1'b0;
    ref_mem[a % DEPTH] = DW'(d);
  endtask

  task automatic cpu_read(input int unsigned a);
    cpu_address = AW'(a);
    #1;
    check($sformatf("cpu_rd[%0d]", a % DEPTH), 32'(cpu_out), 32'(ref_mem[a % DEPTH]));
  endtask

  // Issue one command and compare against the reference. Called aligned just
  // after a rising edge with the engine idle.
  task automatic run_cmd(input bit m, input int unsigned src, input int unsigned dst,
                         input int unsigned len, input int unsigned val, input bit hold);
    int unsigned n;
    int unsigned idx;
    int unsigned a;
    int          exp_busy;
    int          guard;
    bit          desc;
    n    = (len > DEPTH) ? DEPTH : len;
    desc = m && (dst > src);
    exp_q.delete();
    for (int unsigned k = 0; k < n; k++) begin
      idx = desc ? (n - 1 - k) : k;
      a   = (dst + idx) % DEPTH;
      if (m) ref_mem[a] = ref_mem[(src + idx) % DEPTH];
      else   ref_mem[a] = DW'(val);
      exp_q.push_back(a);
    end
    exp_busy = (n == 0) ? 1 : (m ? int'(2 * n + 1) : int'(n + 1));

    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    load_q.delete();
    mode       = m;
    src_addr   = AW'(src);
    dst_addr   = AW'(dst);
    length     = (AW + 1)'(len);
    fill_value = DW'(val);
    start      = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    // CPU tries to write throughout the command; none of it may land.
    cpu_load    = 1'b1;
    cpu_address = AW'($urandom);
    cpu_in      = DW'($urandom);
    guard = 0;
    while (1) begin
      @(negedge clk);
      if (done === 1'b1) begin
        start    = 1'b0;
        cpu_load = 1'b0;
      end
      if (busy !== 1'b1 || guard > 9000) break;
      guard++;
    end
    start    = 1'b0;
    cpu_load = 1'b0;
    check("no_timeout", {31'd0, guard <= 9000}, 32'd1);
    check("busy_cycles", busy_cnt, exp_busy);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_at, exp_busy);
    check_loads("load_order");
    check_mem("mem_image");
    tick;
  endtask

  initial begin
    int unsigned s;
    int unsigned d;
    int unsigned v;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset: writes blocked combinationally, engine idle after the edge.
    cpu_load    = 1'b1;
    cpu_address = 12'd5;
    cpu_in      = 16'hDEAD;
    #1;
    check("rst_load_blocked", 32'(mem_load), 0);
    tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_load_after_edge", 32'(mem_load), 0);
    cpu_load = 1'b0;
    reset_n  = 1'b1;
    tick;
    check_mem("rst_mem_untouched");

    // Fill 8 words at 0.
    run_cmd(1'b0, 0, 0, 8, 16'hA5A5, 1'b0);
    for (int a = 0; a <= 8; a++) cpu_read(a);

    // CPU-seeded ascending copy.
    for (int i = 0; i < 4; i++) cpu_write(100 + i, i + 1);
    run_cmd(1'b1, 100, 200, 4, 0, 1'b0);
    for (int a = 200; a < 204; a++) cpu_read(a);

    // Forward-overlapping copy must walk downwards.
    for (int i = 0; i < 4; i++) cpu_write(10 + i, i + 1);
    run_cmd(1'b1, 10, 12, 4, 0, 1'b0);
    for (int a = 10; a < 16; a++) cpu_read(a);

    // Fill wrapping past the top of memory.
    run_cmd(1'b0, 0, 4094, 4, 7, 1'b0);
    cpu_read(4094); cpu_read(4095); cpu_read(0); cpu_read(1); cpu_read(2);

    // Zero length, and start held high through a command.
    run_cmd(1'b0, 0, 50, 0, 9, 1'b1);
    run_cmd(1'b1, 30, 600, 6, 0, 1'b1);
    run_cmd(1'b1, 600, 597, 6, 0, 1'b0);

    // Oversized length clips to the full memory.
    run_cmd(1'b0, 0, 123, 5000, 16'h1234, 1'b0);

    // Reset in the third cycle of an 8-word fill.
    busy_cnt = 0;
    done_cnt = 0;
    load_q.delete();
    v = 32'h0000_5A5A;
    mode       = 1'b0;
    dst_addr   = 12'd300;
    length     = 13'd8;
    fill_value = DW'(v);
    start      = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    check("abort_load_blocked", 32'(mem_load), 0);
    tick;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    reset_n = 1'b1;
    tick;
    tick;
    check("abort_no_done", done_cnt, 0);
    check("abort_writes", load_q.size(), 2);
    ref_mem[300] = DW'(v);
    ref_mem[301] = DW'(v);
    check_mem("abort_mem");

    // Randomized commands, some with nearby/overlapping ranges.
    for (int k = 0; k < 24; k++) begin
      s = $urandom_range(0, DEPTH - 1);
      if (k % 3 == 0) d = (s + DEPTH - 4 + $urandom_range(0, 8)) % DEPTH;
      else            d = $urandom_range(0, DEPTH - 1);
      if (k % 4 == 1) cpu_write($urandom_range(0, DEPTH - 1), $urandom);
      run_cmd(1'($urandom_range(0, 1)), s, d, $urandom_range(0, 40),
              $urandom, 1'($urandom_range(0, 1)));
    end
    cpu_read(d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
